// File: rtl/decoupler_fifo.sv
// Circular-buffer DTI decoupler: registered ready/valid, explicit pointer wrap, synchronous flush.
// Define DECOUPLER_FIFO_LEVEL_EN to expose the occupancy count on level_o.
module decoupler_fifo #(
    parameter int DEPTH  = 2,
    parameter int W_DATA = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [W_DATA-1:0] din_data_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [W_DATA-1:0] dout_data_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i
`ifdef DECOUPLER_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_o
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 1024) begin : g_bad_depth
        $error("decoupler_fifo: DEPTH must be within 1..1024");
    end

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push, pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never alias.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign din_ready_o  = (cnt_q != CW'(DEPTH));
    assign dout_valid_o = (cnt_q != '0);
    assign dout_data_o  = mem_q[rp_q];
    assign push         = din_valid_i & din_ready_o;
    assign pop          = dout_valid_o & dout_ready_i;

`ifdef DECOUPLER_FIFO_LEVEL_EN
    assign level_o = cnt_q;
`endif

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = ptr_inc(wp_q);
            end
            if (pop) begin
                rp_d = ptr_inc(rp_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is never cleared; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && push) begin
            mem_q[wp_q] <= din_data_i;
        end
    end

endmodule
